// File: rtl/scr_pkg.sv
// scr_pkg: shared constants and lock-state encoding for the 64b/66b receive path
package scr_pkg;
  localparam int TAP_A = 39;
  localparam int TAP_B = 58;
  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;
  typedef enum logic [1:0] {HUNT, SLIP_WAIT, LOCKED} lock_state_t;
endpackage

// File: rtl/descrambler_core.sv
// descrambler_core: combinational x^58+x^39+1 self-synchronous descramble of one 64-bit payload
//   prev    - upper TAP_B bits of the previous scrambled payload (bits 63:64-TAP_B)
//   payload - current scrambled payload, bit 0 first on the wire
//   data    - descrambled payload
module descrambler_core
  import scr_pkg::*;
(
  input  logic [TAP_B-1:0] prev,
  input  logic [63:0]      payload,
  output logic [63:0]      data
);
  logic [TAP_B+63:0] e;
  assign e = {payload, prev};
  assign data = e[TAP_B +: 64] ^ e[TAP_B-TAP_A +: 64] ^ e[63:0];
endmodule

// File: rtl/rx_block_lock_descrambler.sv
// rx_block_lock_descrambler: 66-bit block lock acquisition with bit-slip requests and payload descrambling
//   clock, reset          - clock and synchronous active-high reset
//   in_valid, in_block    - raw block from the gearbox, [65:64] sync header, [63:0] scrambled payload
//   slip                  - one-cycle request to shift gearbox alignment by one bit
//   block_lock            - lock status
//   out_valid             - out_header/out_data carry a block received while locked
//   out_header, out_data  - registered sync header and descrambled payload
//   hdr_err               - the block just emitted had an invalid sync header
module rx_block_lock_descrambler
  import scr_pkg::*;
#(
  parameter int LOCK_CNT  = 64,
  parameter int ERR_LIMIT = 16,
  parameter int WIN_LEN   = 64,
  parameter int SLIP_WAIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [65:0] in_block,
  output logic        slip,
  output logic        block_lock,
  output logic        out_valid,
  output logic [1:0]  out_header,
  output logic [63:0] out_data,
  output logic        hdr_err
);
  localparam int SHW = $clog2(LOCK_CNT + 1);
  localparam int BDW = $clog2(ERR_LIMIT + 1);
  localparam int WNW = $clog2(WIN_LEN + 1);
  localparam int WTW = $clog2(SLIP_WAIT + 1);
  lock_state_t state, state_n;
  logic [SHW-1:0] sh_cnt, sh_cnt_n;
  logic [BDW-1:0] bad_cnt, bad_cnt_n;
  logic [WNW-1:0] win_cnt, win_cnt_n;
  logic [WTW-1:0] wait_cnt, wait_cnt_n;
  logic [TAP_B-1:0] prev;
  logic [63:0] data;
  logic hdr_ok, slip_n;
  assign hdr_ok = in_block[65:64] == SYNC_DATA || in_block[65:64] == SYNC_CTRL;
  assign block_lock = state == LOCKED;
  descrambler_core u_core (.prev(prev), .payload(in_block[63:0]), .data(data));
  always_comb begin
    state_n = state;
    sh_cnt_n = sh_cnt;
    bad_cnt_n = bad_cnt;
    win_cnt_n = win_cnt;
    wait_cnt_n = wait_cnt;
    slip_n = 1'b0;
    if (in_valid)
      case (state)
        HUNT:
          if (!hdr_ok) begin
            slip_n = 1'b1;
            sh_cnt_n = '0;
            wait_cnt_n = '0;
            state_n = scr_pkg::SLIP_WAIT;
          end else if (sh_cnt == SHW'(LOCK_CNT - 1)) begin
            state_n = LOCKED;
            sh_cnt_n = '0;
            bad_cnt_n = '0;
            win_cnt_n = '0;
          end else
            sh_cnt_n = sh_cnt + 1'b1;
        scr_pkg::SLIP_WAIT:
          if (wait_cnt == WTW'(SLIP_WAIT - 1)) begin
            state_n = HUNT;
            wait_cnt_n = '0;
          end else
            wait_cnt_n = wait_cnt + 1'b1;
        LOCKED:
          // loss of lock is tested first so it wins over the window wrap
          if (!hdr_ok && bad_cnt == BDW'(ERR_LIMIT - 1)) begin
            slip_n = 1'b1;
            state_n = scr_pkg::SLIP_WAIT;
            bad_cnt_n = '0;
            win_cnt_n = '0;
            wait_cnt_n = '0;
          end else if (win_cnt == WNW'(WIN_LEN - 1)) begin
            bad_cnt_n = '0;
            win_cnt_n = '0;
          end else begin
            win_cnt_n = win_cnt + 1'b1;
            bad_cnt_n = bad_cnt + BDW'(!hdr_ok);
          end
        default: state_n = HUNT;
      endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= HUNT;
      sh_cnt <= '0;
      bad_cnt <= '0;
      win_cnt <= '0;
      wait_cnt <= '0;
      prev <= '0;
      slip <= 1'b0;
      out_valid <= 1'b0;
      out_header <= '0;
      out_data <= '0;
      hdr_err <= 1'b0;
    end else begin
      state <= state_n;
      sh_cnt <= sh_cnt_n;
      bad_cnt <= bad_cnt_n;
      win_cnt <= win_cnt_n;
      wait_cnt <= wait_cnt_n;
      slip <= slip_n;
      out_valid <= in_valid && state == LOCKED;
      if (in_valid) begin
        prev <= in_block[63:64-TAP_B];
        out_header <= in_block[65:64];
        out_data <= data;
        hdr_err <= !hdr_ok;
      end
    end
  end
endmodule
